// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie the port that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of the SRAM controller: latches the granted op, holds it
// on the controller until completion, stalls the other master, and aborts hung accesses.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_rd_en,
  input  logic              r0_wr_en,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_write_data,
  output logic [DATA_W-1:0] r0_read_data,
  output logic              r0_stall,
  input  logic              r1_rd_en,
  input  logic              r1_wr_en,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_write_data,
  output logic [DATA_W-1:0] r1_read_data,
  output logic              r1_stall,
  output logic              ctrl_rd_en,
  output logic              ctrl_wr_en,
  output logic [ADDR_W-1:0] ctrl_address,
  output logic [DATA_W-1:0] ctrl_write_data,
  input  logic [DATA_W-1:0] ctrl_read_data,
  input  logic              ctrl_busy,
  output logic              timeout_err,
  output state_t            dbg_state
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Handshake: a master raises rd/wr (request) and holds it with address/data stable
  // until its stall output is low; the op retires on the clock edge where req & !stall.

  state_t            state;
  logic              last_grant;
  logic [CNT_W-1:0]  wd_cnt;
  logic [DATA_W-1:0] held0;
  logic [DATA_W-1:0] held1;

  logic [1:0] req;
  logic [1:0] grant;
  logic       in_busy;
  logic       wd_expire;
  logic       done;
  logic       done0;
  logic       done1;
  logic       rd_ok0;
  logic       rd_ok1;
  logic       op_rd;
  logic       op_wr;

  assign req[PORT0] = r0_rd_en | r0_wr_en;
  assign req[PORT1] = r1_rd_en | r1_wr_en;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_grant),
    .grant (grant)
  );

  assign op_rd = grant[PORT1] ? r1_rd_en : r0_rd_en;
  assign op_wr = grant[PORT1] ? r1_wr_en : r0_wr_en;

  // A completion is either the controller dropping busy or the watchdog giving up.
  assign in_busy   = (state == BUSY0) || (state == BUSY1);
  assign wd_expire = in_busy && ctrl_busy && (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign done      = in_busy && (!ctrl_busy || wd_expire);
  assign done0     = (state == BUSY0) && done;
  assign done1     = (state == BUSY1) && done;

  // Only a genuine (non-aborted) read completion delivers controller data.
  assign rd_ok0 = done0 && !ctrl_busy && ctrl_rd_en;
  assign rd_ok1 = done1 && !ctrl_busy && ctrl_rd_en;

  assign r0_stall     = req[PORT0] & ~done0;
  assign r1_stall     = req[PORT1] & ~done1;
  assign r0_read_data = rd_ok0 ? ctrl_read_data : held0;
  assign r1_read_data = rd_ok1 ? ctrl_read_data : held1;
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ctrl_rd_en      <= 1'b0;
      ctrl_wr_en      <= 1'b0;
      ctrl_address    <= '0;
      ctrl_write_data <= '0;
      last_grant      <= 1'b1;
      wd_cnt          <= '0;
      timeout_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            state           <= grant[PORT1] ? BUSY1 : BUSY0;
            ctrl_address    <= grant[PORT1] ? r1_address : r0_address;
            ctrl_write_data <= grant[PORT1] ? r1_write_data : r0_write_data;
            ctrl_wr_en      <= op_wr;
            ctrl_rd_en      <= op_rd & ~op_wr;
            last_grant      <= grant[PORT1];
            wd_cnt          <= '0;
          end
        end
        BUSY0, BUSY1: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (done) begin
            state      <= IDLE;
            ctrl_rd_en <= 1'b0;
            ctrl_wr_en <= 1'b0;
          end
          if (wd_expire) begin
            timeout_err <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          ctrl_rd_en <= 1'b0;
          ctrl_wr_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held0 <= '0;
      held1 <= '0;
    end else begin
      if (rd_ok0) held0 <= ctrl_read_data;
      if (rd_ok1) held1 <= ctrl_read_data;
    end
  end

endmodule
